// File: rtl/magic_device_arbiter_pkg.sv
// ============================================================================
// Module   : magic_arb_pkg
// Purpose  : Shared state encoding and width helpers for the device arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package magic_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int CNT_W = 32;

   // Timer must be able to hold TIMEOUT itself, hence the +1.
   function automatic int tmr_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/magic_device_arbiter_picker.sv
// ============================================================================
// Module   : magic_rr_picker
// Purpose  : Combinational round-robin picker; first set request from ptr up.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module magic_rr_picker #(
   parameter int NREQ  = 4,
   parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic             any,
   output logic [PTR_W-1:0] idx,
   output logic [NREQ-1:0]  onehot
);

   int w_cand;

   // Scan from the far end back towards ptr so the nearest hit overwrites.
   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      w_cand = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_cand = (int'(ptr) + k) % NREQ;
         if (req[w_cand]) begin
            any = 1'b1;
            idx = PTR_W'(w_cand);
         end
      end
      if (any) onehot[idx] = 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/magic_device_arbiter.sv
// ============================================================================
// Module   : magic_device_arbiter
// Purpose  : Round-robin share of one device read port among NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module magic_device_arbiter
   import magic_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int SEL_W   = 12,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*SEL_W-1:0]   req_select,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         resp_valid,
   output logic [DATA_W-1:0]       resp_data,
   output logic                    resp_err,
   input  logic [NREQ-1:0]         resp_ready,
   output logic [SEL_W-1:0]        dev_read_select,
   output logic                    dev_read_ready,
   input  logic                    dev_read_valid,
   input  logic [DATA_W-1:0]       dev_read_data,
   output logic                    busy,
   output logic [CNT_W-1:0]        txn_count
);

   localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int c_TMR_W = tmr_width(TIMEOUT);
   localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NREQ - 1);

   state_t              r_state;
   logic [c_PTR_W-1:0]  r_rr_ptr;
   logic [c_PTR_W-1:0]  r_owner;
   logic [SEL_W-1:0]    r_sel_q;
   logic [DATA_W-1:0]   r_data_q;
   logic                r_err_q;
   logic [c_TMR_W-1:0]  r_timer;
   logic [CNT_W-1:0]    r_txn_count;

   logic                w_any;
   logic [c_PTR_W-1:0]  w_win;
   logic [NREQ-1:0]     w_win_oh;
   logic [SEL_W-1:0]    w_win_sel;
   logic [NREQ-1:0]     w_owner_oh;

   magic_rr_picker #(
      .NREQ   (NREQ),
      .PTR_W  (c_PTR_W)
   ) u_picker (
      .req    (req_valid),
      .ptr    (r_rr_ptr),
      .any    (w_any),
      .idx    (w_win),
      .onehot (w_win_oh)
   );

   assign w_win_sel  = req_select[int'(w_win)*SEL_W +: SEL_W];
   assign w_owner_oh = NREQ'(1) << r_owner;

   // Grant is masked during reset so every output reads 0 immediately.
   assign req_ready       = (r_state == IDLE && !reset) ? w_win_oh : '0;
   assign resp_valid      = (r_state == RESP) ? w_owner_oh : '0;
   assign resp_data       = (r_state == RESP) ? r_data_q : '0;
   assign resp_err        = (r_state == RESP) && r_err_q;
   assign dev_read_ready  = (r_state == ISSUE);
   assign dev_read_select = (r_state == ISSUE) ? r_sel_q : '0;
   assign busy            = (r_state != IDLE);
   assign txn_count       = r_txn_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_sel_q     <= '0;
         r_data_q    <= '0;
         r_err_q     <= 1'b0;
         r_timer     <= '0;
         r_txn_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner  <= w_win;
                  r_sel_q  <= w_win_sel;
                  r_rr_ptr <= (w_win == c_PTR_LAST) ? '0 : w_win + 1'b1;
                  r_timer  <= '0;
                  r_state  <= ISSUE;
               end
            end
            ISSUE: begin
               // A device answer on the last allowed cycle beats the timeout.
               if (dev_read_valid) begin
                  r_state <= WAIT;
               end else if (r_timer == c_TMR_LAST) begin
                  r_data_q <= '0;
                  r_err_q  <= 1'b1;
                  r_state  <= RESP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            WAIT: begin
               r_data_q <= dev_read_data;
               r_err_q  <= 1'b0;
               r_state  <= RESP;
            end
            RESP: begin
               if (resp_ready[r_owner]) begin
                  r_txn_count <= r_txn_count + 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_magic_device_arbiter.sv
// ============================================================================
// Module   : tb_magic_device_arbiter
// Purpose  : Directed self-checking bench for magic_device_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_magic_device_arbiter;

   localparam int NREQ    = 4;
   localparam int SEL_W   = 12;
   localparam int DATA_W  = 64;
   localparam int TIMEOUT = 8;

   logic                  clock;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*SEL_W-1:0] req_select;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       resp_valid;
   logic [DATA_W-1:0]     resp_data;
   logic                  resp_err;
   logic [NREQ-1:0]       resp_ready;
   logic [SEL_W-1:0]      dev_read_select;
   logic                  dev_read_ready;
   logic                  dev_read_valid;
   logic [DATA_W-1:0]     dev_read_data;
   logic                  busy;
   logic [31:0]           txn_count;

   int total = 0;
   int bad   = 0;

   magic_device_arbiter #(
      .NREQ    (NREQ),
      .SEL_W   (SEL_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_select      (req_select),
      .req_ready       (req_ready),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .resp_err        (resp_err),
      .resp_ready      (resp_ready),
      .dev_read_select (dev_read_select),
      .dev_read_ready  (dev_read_ready),
      .dev_read_valid  (dev_read_valid),
      .dev_read_data   (dev_read_data),
      .busy            (busy),
      .txn_count       (txn_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic test_reset();
      @(negedge clock);
      #1;
      total++;
      if ({req_ready, resp_valid, resp_data, resp_err, dev_read_select,
           dev_read_ready, busy, txn_count} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got rv=%b rd=%h busy=%b cnt=%0d want all 0",
                  resp_valid, resp_data, busy, txn_count);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || txn_count !== 32'd0) begin
         bad++;
         $display("FAIL reset_release: got busy=%b cnt=%0d want 0 0", busy, txn_count);
      end
   endtask

   task automatic test_single();
      @(negedge clock);
      req_select[1*SEL_W +: SEL_W] = 12'h0A5;
      req_valid      = 4'b0010;
      dev_read_valid = 1'b1;
      dev_read_data  = 64'hDEADBEEF_00000001;
      resp_ready     = 4'b0000;
      #1;
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL single_grant: got %b want 0010", req_ready);
      end
      @(negedge clock);
      req_valid = 4'b0000;
      #1;
      total++;
      if (dev_read_ready !== 1'b1 || dev_read_select !== 12'h0A5) begin
         bad++;
         $display("FAIL single_issue: got rdy=%b sel=%h want 1 0a5", dev_read_ready, dev_read_select);
      end
      @(negedge clock);
      #1;
      total++;
      if (resp_valid !== 4'b0000 || dev_read_ready !== 1'b0) begin
         bad++;
         $display("FAIL single_wait: got rv=%b rdy=%b want 0000 0", resp_valid, dev_read_ready);
      end
      @(negedge clock);
      resp_ready = 4'b0010;
      #1;
      total++;
      if (resp_valid !== 4'b0010 || resp_data !== 64'hDEADBEEF_00000001 || resp_err !== 1'b0) begin
         bad++;
         $display("FAIL single_resp: got rv=%b d=%h e=%b want 0010 deadbeef00000001 0",
                  resp_valid, resp_data, resp_err);
      end
      @(negedge clock);
      resp_ready = 4'b0000;
      #1;
      total++;
      if (txn_count !== 32'd1 || resp_valid !== 4'b0000) begin
         bad++;
         $display("FAIL single_count: got cnt=%0d rv=%b want 1 0000", txn_count, resp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]       exp_oh;
      logic [SEL_W-1:0] exp_sel;
      @(negedge clock);
      reset = 1'b1;
      req_valid = '0; resp_ready = '0; dev_read_valid = 1'b0;
      @(negedge clock);
      reset          = 1'b0;
      req_select     = {12'h333, 12'h222, 12'h111, 12'h000};
      req_valid      = 4'b1111;
      resp_ready     = 4'b1111;
      dev_read_valid = 1'b1;
      dev_read_data  = 64'h0000_1234_5678_9ABC;
      for (int t = 0; t < 5; t++) begin
         exp_oh  = 4'b0001 << (t % 4);
         exp_sel = SEL_W'(12'h111 * (t % 4));
         if (t > 0) @(negedge clock);
         #1;
         total++;
         if (req_ready !== exp_oh) begin
            bad++;
            $display("FAIL rr_grant%0d: got %b want %b", t, req_ready, exp_oh);
         end
         @(negedge clock);
         #1;
         total++;
         if (dev_read_select !== exp_sel) begin
            bad++;
            $display("FAIL rr_select%0d: got %h want %h", t, dev_read_select, exp_sel);
         end
         @(negedge clock);
         @(negedge clock);
         #1;
         total++;
         if (resp_valid !== exp_oh || resp_data !== 64'h0000_1234_5678_9ABC) begin
            bad++;
            $display("FAIL rr_resp%0d: got rv=%b d=%h want %b 0000123456789abc", t, resp_valid, resp_data, exp_oh);
         end
      end
      @(negedge clock);
      req_valid = 4'b0000;
      #1;
      total++;
      if (txn_count !== 32'd5) begin
         bad++;
         $display("FAIL rr_count: got %0d want 5", txn_count);
      end
   endtask

   task automatic test_timeout();
      int n;
      @(negedge clock);
      req_select[0 +: SEL_W] = 12'h055;
      req_valid      = 4'b0001;
      dev_read_valid = 1'b0;
      resp_ready     = 4'b0001;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL to_grant: got %b want 0001", req_ready);
      end
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         req_valid = 4'b0000;
         #1;
         if (dev_read_ready) n++;
         else break;
      end
      total++;
      if (n !== TIMEOUT) begin
         bad++;
         $display("FAIL to_issue_cycles: got %0d want %0d", n, TIMEOUT);
      end
      total++;
      if (resp_valid !== 4'b0001 || resp_data !== 64'd0 || resp_err !== 1'b1) begin
         bad++;
         $display("FAIL to_resp: got rv=%b d=%h e=%b want 0001 0 1", resp_valid, resp_data, resp_err);
      end
      @(negedge clock);
      resp_ready = 4'b0000;
      #1;
      total++;
      if (txn_count !== 32'd6) begin
         bad++;
         $display("FAIL to_count: got %0d want 6", txn_count);
      end
      @(negedge clock);
      req_select[2*SEL_W +: SEL_W] = 12'h2A2;
      req_valid      = 4'b0100;
      dev_read_valid = 1'b1;
      dev_read_data  = 64'h0000_0000_CAFE_F00D;
      #1;
      total++;
      if (req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL to_next_grant: got %b want 0100", req_ready);
      end
      @(negedge clock);
      req_valid = 4'b0000;
      @(negedge clock);
      @(negedge clock);
      resp_ready = 4'b0100;
      #1;
      total++;
      if (resp_valid !== 4'b0100 || resp_data !== 64'h0000_0000_CAFE_F00D || resp_err !== 1'b0) begin
         bad++;
         $display("FAIL to_next_resp: got rv=%b d=%h e=%b want 0100 cafef00d 0", resp_valid, resp_data, resp_err);
      end
      @(negedge clock);
      resp_ready = 4'b0000;
      #1;
      total++;
      if (txn_count !== 32'd7) begin
         bad++;
         $display("FAIL to_next_count: got %0d want 7", txn_count);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clock);
      req_select[3*SEL_W +: SEL_W] = 12'h3C3;
      req_valid      = 4'b1000;
      dev_read_valid = 1'b1;
      dev_read_data  = 64'h0123_4567_89AB_CDEF;
      resp_ready     = 4'b0000;
      #1;
      total++;
      if (req_ready !== 4'b1000) begin
         bad++;
         $display("FAIL bp_grant: got %b want 1000", req_ready);
      end
      @(negedge clock);
      req_valid = 4'b0000;
      @(negedge clock);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         req_valid     = 4'b0111;
         resp_ready    = 4'b0111;
         dev_read_data = 64'hFFFF_0000_FFFF_0000;
         #1;
         total++;
         if (resp_valid !== 4'b1000 || resp_data !== 64'h0123_4567_89AB_CDEF || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: got rv=%b d=%h e=%b want 1000 0123456789abcdef 0",
                     k, resp_valid, resp_data, resp_err);
         end
         total++;
         if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL bp_no_grant%0d: got %b want 0000", k, req_ready);
         end
      end
      @(negedge clock);
      req_valid  = 4'b0000;
      resp_ready = 4'b1000;
      @(negedge clock);
      resp_ready = 4'b0000;
      #1;
      total++;
      if (txn_count !== 32'd8 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_count: got cnt=%0d busy=%b want 8 0", txn_count, busy);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      req_valid      = 4'b0100;
      dev_read_valid = 1'b0;
      resp_ready     = 4'b0000;
      #1;
      total++;
      if (req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL rst_grant: got %b want 0100", req_ready);
      end
      @(negedge clock);
      req_valid = 4'b1111;
      #1;
      total++;
      if (dev_read_ready !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_in_issue: got rdy=%b busy=%b want 1 1", dev_read_ready, busy);
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({req_ready, resp_valid, resp_data, resp_err, dev_read_select,
           dev_read_ready, busy, txn_count} !== '0) begin
         bad++;
         $display("FAIL rst_async: got rr=%b rdy=%b sel=%h busy=%b cnt=%0d want all 0",
                  req_ready, dev_read_ready, dev_read_select, busy, txn_count);
      end
      @(negedge clock);
      @(negedge clock);
      reset          = 1'b0;
      dev_read_valid = 1'b1;
      dev_read_data  = 64'h5555_AAAA_5555_AAAA;
      resp_ready     = 4'b1111;
      #1;
      total++;
      if (req_ready !== 4'b0001 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_regrant: got rr=%b busy=%b want 0001 0", req_ready, busy);
      end
      @(negedge clock);
      req_valid = 4'b0000;
      @(negedge clock);
      @(negedge clock);
      #1;
      total++;
      if (resp_valid !== 4'b0001 || resp_data !== 64'h5555_AAAA_5555_AAAA) begin
         bad++;
         $display("FAIL rst_resp: got rv=%b d=%h want 0001 5555aaaa5555aaaa", resp_valid, resp_data);
      end
      @(negedge clock);
      resp_ready = 4'b0000;
      #1;
      total++;
      if (txn_count !== 32'd1) begin
         bad++;
         $display("FAIL rst_count: got %0d want 1", txn_count);
      end
   endtask

   task automatic test_coincident();
      @(negedge clock);
      req_select[1*SEL_W +: SEL_W] = 12'h0A5;
      req_valid      = 4'b0010;
      dev_read_valid = 1'b0;
      dev_read_data  = 64'hA5A5_5A5A_0F0F_F0F0;
      resp_ready     = 4'b0010;
      #1;
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL co_grant: got %b want 0010", req_ready);
      end
      for (int k = 0; k < TIMEOUT - 1; k++) begin
         @(negedge clock);
         req_valid = 4'b0000;
      end
      @(negedge clock);
      dev_read_valid = 1'b1;
      #1;
      total++;
      if (dev_read_ready !== 1'b1) begin
         bad++;
         $display("FAIL co_last_issue: got %b want 1", dev_read_ready);
      end
      @(negedge clock);
      dev_read_valid = 1'b0;
      #1;
      total++;
      if (dev_read_ready !== 1'b0 || resp_valid !== 4'b0000 || busy !== 1'b1) begin
         bad++;
         $display("FAIL co_wait: got rdy=%b rv=%b busy=%b want 0 0000 1", dev_read_ready, resp_valid, busy);
      end
      @(negedge clock);
      #1;
      total++;
      if (resp_valid !== 4'b0010 || resp_data !== 64'hA5A5_5A5A_0F0F_F0F0 || resp_err !== 1'b0) begin
         bad++;
         $display("FAIL co_resp: got rv=%b d=%h e=%b want 0010 a5a55a5a0f0ff0f0 0", resp_valid, resp_data, resp_err);
      end
      @(negedge clock);
      resp_ready = 4'b0000;
      #1;
      total++;
      if (txn_count !== 32'd2) begin
         bad++;
         $display("FAIL co_count: got %0d want 2", txn_count);
      end
   endtask

   initial begin
      reset          = 1'b1;
      req_valid      = '0;
      req_select     = '0;
      resp_ready     = '0;
      dev_read_valid = 1'b0;
      dev_read_data  = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_coincident();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
